// File: rtl/data_source_pkg.sv
// Shared definitions for the multi-channel data source.
// FSM state encoding used by multi_data_source.
package data_source_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ds_state_t;

endpackage

// File: rtl/ds_buffer.sv
// Sample buffer: one write port, one registered read port.
// The read register is cleared by rst; the array itself is not.
module ds_buffer #(
    parameter int WIDTH = 32,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    // Array write, no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read register only updates on rd_en so a stalled word stays put.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/multi_data_source.sv
// Replays a channel-interleaved sample memory N_LOOPS times with pacing.
// Optional DATA_SOURCE_META_EN puts the loop count on out_m.
module multi_data_source
    import data_source_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MWIDTH       = 8,
    parameter int N_CHANNELS   = 4,
    parameter int LOGNCHANNELS = 2,
    parameter int N_DATA       = 16,
    parameter int LOGNDATA     = 4,
    parameter int SENDNTH      = 2,
    parameter int LOGSENDNTH   = 1,
    parameter int N_LOOPS      = 3,
    parameter int LOGNLOOPS    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_en,
    input  logic [LOGNCHANNELS+LOGNDATA-1:0] ld_addr,
    input  logic [WIDTH-1:0]                 ld_data,
    input  logic                             start,
    input  logic                             out_ready,
    output logic                             out_nd,
    output logic [WIDTH-1:0]                 out_data,
    output logic [LOGNCHANNELS-1:0]          out_ch,
    output logic [MWIDTH-1:0]                out_m,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int AW = LOGNCHANNELS + LOGNDATA;
    localparam int GW = LOGSENDNTH + 1;

    ds_state_t state, state_nxt;

    logic [LOGNDATA-1:0]     idx;
    logic [LOGNCHANNELS-1:0] ch;
    logic [LOGNLOOPS-1:0]    loop_cnt;
    logic                    last_fetched;
    logic [GW-1:0]           gap;

    logic fire, finish, accept, gap_ok;
    logic ch_last, idx_last, loop_last;

    assign accept    = out_nd && out_ready;
    assign gap_ok    = gap >= GW'(SENDNTH - 1);
    assign ch_last   = ch == LOGNCHANNELS'(N_CHANNELS - 1);
    assign idx_last  = idx == LOGNDATA'(N_DATA - 1);
    assign loop_last = loop_cnt == LOGNLOOPS'(N_LOOPS - 1);
    assign busy      = state == RUN;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus fetch/finish strobes. A fetch reads the buffer and
    // presents the word on the following cycle, so start itself fetches.
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    fire      = 1'b1;
                end
            end
            RUN: begin
                if (accept && last_fetched) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end else if (!last_fetched) begin
                    if (out_nd)
                        fire = accept && (SENDNTH == 1);
                    else
                        fire = gap_ok;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Position of the next word to fetch; wraps to zero after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            ch           <= '0;
            loop_cnt     <= '0;
            last_fetched <= 1'b0;
        end else if (fire) begin
            ch <= ch_last ? '0 : ch + 1'b1;
            if (ch_last) begin
                idx <= idx_last ? '0 : idx + 1'b1;
                if (idx_last)
                    loop_cnt <= loop_last ? '0 : loop_cnt + 1'b1;
            end
            last_fetched <= ch_last && idx_last && loop_last;
        end else if (finish) begin
            last_fetched <= 1'b0;
        end
    end

    // Output valid, channel tag and cycles-since-acceptance pacing count.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_nd <= 1'b0;
            out_ch <= '0;
            gap    <= '0;
        end else begin
            if (fire) begin
                out_nd <= 1'b1;
                out_ch <= ch;
            end else if (accept) begin
                out_nd <= 1'b0;
            end
            if (accept)
                gap <= GW'(1);
            else if (gap < GW'(SENDNTH))
                gap <= gap + 1'b1;
        end
    end

`ifdef DATA_SOURCE_META_EN
    // Loop number of the word being presented.
    always_ff @(posedge clk) begin
        if (rst)
            out_m <= '0;
        else if (fire)
            out_m <= MWIDTH'(loop_cnt);
    end
`else
    assign out_m = '0;
`endif

    // Sticky error on writes or start while running; one-cycle done.
    always_ff @(posedge clk) begin
        if (rst) begin
            error <= 1'b0;
            done  <= 1'b0;
        end else begin
            if ((state == RUN) && (ld_en || start))
                error <= 1'b1;
            done <= finish;
        end
    end

    ds_buffer #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ld_en && (state != RUN)),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (fire),
        .rd_addr ({ch, idx}),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_multi_data_source.sv
// Self-checking bench for multi_data_source (default and SENDNTH=3 builds).
// Expected words come from a sample-order model over a shadow memory.
module tb_multi_data_source;

    localparam int W     = 32;
    localparam int MW    = 8;
    localparam int NC    = 4;
    localparam int LNC   = 2;
    localparam int ND    = 16;
    localparam int LND   = 4;
    localparam int NL    = 3;
    localparam int AW    = LNC + LND;
    localparam int WORDS = NC * ND * NL;
`ifdef DATA_SOURCE_META_EN
    localparam bit META = 1'b1;
`else
    localparam bit META = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;

    logic           out_nd, busy, done, error;
    logic [W-1:0]   out_data;
    logic [LNC-1:0] out_ch;
    logic [MW-1:0]  out_m;

    logic           nd3, busy3, done3, err3;
    logic [W-1:0]   data3;
    logic [LNC-1:0] ch3;
    logic [MW-1:0]  m3;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem_m [NC*ND];

    always #5 clk = ~clk;

    multi_data_source dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .out_ready(out_ready),
        .out_nd(out_nd), .out_data(out_data), .out_ch(out_ch),
        .out_m(out_m), .busy(busy), .done(done), .error(error)
    );

    multi_data_source #(.SENDNTH(3), .LOGSENDNTH(2)) dut3 (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .out_ready(out_ready),
        .out_nd(nd3), .out_data(data3), .out_ch(ch3),
        .out_m(m3), .busy(busy3), .done(done3), .error(err3)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Word n of a run: loop-major, then sample index, channel innermost.
    function automatic void expect_word(input int n,
                                        output logic [W-1:0] d,
                                        output logic [LNC-1:0] c,
                                        output logic [MW-1:0] m);
        int lp, r, ix, cc;
        lp = n / (NC * ND);
        r  = n % (NC * ND);
        ix = r / NC;
        cc = r % NC;
        d  = mem_m[cc * ND + ix];
        c  = cc[LNC-1:0];
        m  = META ? lp[MW-1:0] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int a, input logic [W-1:0] v);
        ld_en   = 1'b1;
        ld_addr = a[AW-1:0];
        ld_data = v;
        mem_m[a] = v;
        tick();
        ld_en = 1'b0;
    endtask

    // mode 0: ready=1; 1: random ready; 2: 5-cycle stall at word 50;
    // 3: ready=1 with ld_en and start pulsed mid-run.
    task automatic run_seq(input int mode, input int rst_at);
        int n, done_cnt, tail, last_acc;
        bit fin, held, r;
        int stall;
        logic [W-1:0]   ed, hd;
        logic [LNC-1:0] ec, hc;
        logic [MW-1:0]  em, hm;
        n = 0; done_cnt = 0; tail = 0; last_acc = -1;
        fin = 0; held = 0; stall = 0;
        hd = '0; hc = '0; hm = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_nd", out_nd, 1);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (rst_at >= 0 && n == rst_at) begin
                rst = 1'b1;
                out_ready = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_nd", out_nd, 0);
                chk("rst_busy", busy, 0);
                repeat (3) begin
                    tick();
                    chk("rst_idle_nd", out_nd, 0);
                end
                return;
            end
            case (mode)
                1: r = 1'($urandom_range(0, 1));
                2: begin
                    r = !(n == 50 && stall < 5);
                    if (!r) stall++;
                end
                default: r = 1'b1;
            endcase
            out_ready = r;
            ld_en     = (mode == 3) && (cyc == 20);
            ld_addr   = AW'(5);
            ld_data   = 32'hDEAD_BEEF;
            start     = (mode == 3) && (cyc == 30);
            if (cyc == 10) chk("busy_run", busy, 1);
            if (out_nd) begin
                if (held) begin
                    chk("hold_data", out_data, hd);
                    chk("hold_ch", out_ch, hc);
                    chk("hold_m", out_m, hm);
                end
                if (r) begin
                    expect_word(n, ed, ec, em);
                    chk($sformatf("w%0d_data", n), out_data, ed);
                    chk($sformatf("w%0d_ch", n), out_ch, ec);
                    chk($sformatf("w%0d_m", n), out_m, em);
                    if (last_acc >= 0) begin
                        if (mode == 0 || mode == 3)
                            chk("gap_exact", cyc - last_acc, 2);
                        else
                            chk("gap_min", (cyc - last_acc) >= 2, 1);
                    end
                    last_acc = cyc;
                    n++;
                    held = 0;
                end else begin
                    held = 1;
                    hd = out_data; hc = out_ch; hm = out_m;
                end
            end
            tick();
            if (done) done_cnt++;
            if (done_cnt > 0) begin
                chk("tail_nd", out_nd, 0);
                tail++;
                if (tail > 4) fin = 1;
            end
        end
        ld_en = 1'b0;
        start = 1'b0;
        if (!fin) chk("timeout", 1, 0);
        chk("word_count", n, WORDS);
        chk("done_pulses", done_cnt, 1);
        chk("busy_end", busy, 0);
        chk("error_end", error, mode == 3);
    endtask

    typedef struct {
        logic rst, start, ld, rdy;
        logic nd, busy, err;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n3, last3;
        logic [W-1:0]   ed;
        logic [LNC-1:0] ec;
        logic [MW-1:0]  em;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd16};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd16};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_nd", out_nd, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_m", out_m, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        for (int a = 0; a < NC * ND; a++) load(a, W'(a));

        ld_addr = '0;
        ld_data = 32'h0000_0BAD;
        for (int i = 0; i < 8; i++) begin
            rst       = tbl[i].rst;
            start     = tbl[i].start;
            ld_en     = tbl[i].ld;
            out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("t%0d_nd", i), out_nd, tbl[i].nd);
            chk($sformatf("t%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("t%0d_err", i), error, tbl[i].err);
            chk($sformatf("t%0d_data", i), out_data, tbl[i].data);
        end
        rst = 1'b0; start = 1'b0; ld_en = 1'b0; out_ready = 1'b0;

        run_seq(0, -1);
        load(5, 32'h1234_5678);
        run_seq(0, -1);

        do_rst();
        run_seq(2, -1);

        do_rst();
        run_seq(3, -1);
        repeat (3) tick();
        chk("error_sticky", error, 1);

        do_rst();
        run_seq(0, 40);
        run_seq(0, -1);

        do_rst();
        for (int a = 0; a < NC * ND; a++) load(a, W'($urandom));
        run_seq(1, -1);

        do_rst();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_nd3", nd3, 1);
        n3 = 0;
        last3 = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (nd3) begin
                expect_word(n3, ed, ec, em);
                chk($sformatf("s%0d_data", n3), data3, ed);
                chk($sformatf("s%0d_ch", n3), ch3, ec);
                if (last3 >= 0) chk("gap3", cyc - last3, 3);
                last3 = cyc;
                n3++;
            end
            tick();
        end
        chk("n3", n3, 20);
        do_rst();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
